// File: rtl/mac_operand_fifo.sv
// mac_operand_fifo: 4-entry circular operand buffer for the MAC datapath.
// It holds the storage, the write/read pointers and the wrap-parity bit (Round)
// that the downstream ready-mask stage decodes. The read side is
// first-word-fall-through: the head entry is always presented on PopData.
module mac_operand_fifo #(
  parameter int DataWidth   = 16,
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Flush,
  input  logic                   Push,
  input  logic [DataWidth-1:0]   PushData,
  input  logic                   Pop,
  output logic [DataWidth-1:0]   PopData,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Round,
  output logic                   Full,
  output logic                   Empty,
  output logic [BufferWidth:0]   Count,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam logic [BufferWidth-1:0] PTR_LAST_C = BufferWidth'(BufferSize - 32'd1);
  localparam logic [BufferWidth:0]   BUF_SIZE_C = (BufferWidth + 1)'(BufferSize);

  logic [DataWidth-1:0] mem_r [BufferSize];

  logic                 clear_s;
  logic                 pop_ok_s;
  logic                 push_ok_s;
  logic                 w_wrap_s;
  logic                 r_wrap_s;
  logic                 ptr_eq_s;
  logic [BufferWidth:0] count_s;

  // Pointer advance; natural overflow of the pointer width gives the modulo wrap.
  function automatic logic [BufferWidth-1:0] ptr_inc(input logic [BufferWidth-1:0] ptr);
    return ptr + BufferWidth'(32'd1);
  endfunction

  // Status decode from registered pointers only, plus accept/wrap qualification.
  always_comb begin
    clear_s   = rst || Flush;
    ptr_eq_s  = (W_Addr == R_Addr);
    Full      = Round && ptr_eq_s;
    Empty     = !Round && ptr_eq_s;
    // A full buffer still accepts a push when the head is consumed in the same cycle.
    pop_ok_s  = Pop && !Empty && !clear_s;
    push_ok_s = Push && (!Full || Pop) && !clear_s;
    w_wrap_s  = push_ok_s && (W_Addr == PTR_LAST_C);
    r_wrap_s  = pop_ok_s && (R_Addr == PTR_LAST_C);
    count_s   = {1'b0, W_Addr} - {1'b0, R_Addr};
    if (Round) begin
      count_s = count_s + BUF_SIZE_C;
    end else begin
      count_s = count_s;
    end
    Count     = count_s;
    PopData   = mem_r[R_Addr];
  end

  // Operand storage; never cleared, so a flush only drops the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[W_Addr] <= PushData;
    end
  end

  // Pointers, wrap parity and sticky error flags.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      W_Addr    <= '0;
      R_Addr    <= '0;
      Round     <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (push_ok_s) begin
        W_Addr <= ptr_inc(W_Addr);
      end
      if (pop_ok_s) begin
        R_Addr <= ptr_inc(R_Addr);
      end
      // Round flips only when exactly one pointer wraps this cycle.
      Round <= Round ^ (w_wrap_s ^ r_wrap_s);
      if (Push && !push_ok_s) begin
        Overflow <= 1'b1;
      end
      if (Pop && Empty) begin
        Underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_fifo.sv
// Bench for mac_operand_fifo: a directed vector table covering the reset,
// fill/overflow/drain, simultaneous push+pop and flush scenarios, followed by
// randomized traffic checked against a queue-based reference model.
module tb_mac_operand_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        Flush;
  logic        Push;
  logic [15:0] PushData;
  logic        Pop;
  logic [15:0] PopData;
  logic [1:0]  W_Addr;
  logic [1:0]  R_Addr;
  logic        Round;
  logic        Full;
  logic        Empty;
  logic [2:0]  Count;
  logic        Overflow;
  logic        Underflow;

  int n_cmp = 0;
  int n_bad = 0;

  mac_operand_fifo #(.DataWidth(16), .BufferWidth(2), .BufferSize(4)) dut (
    .clk(clk), .rst(rst), .Flush(Flush), .Push(Push), .PushData(PushData), .Pop(Pop),
    .PopData(PopData), .W_Addr(W_Addr), .R_Addr(R_Addr), .Round(Round), .Full(Full),
    .Empty(Empty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        push;
    logic        pop;
    logic [15:0] data;
    int          w;
    int          r;
    int          rnd;
    int          cnt;
    int          ov;
    int          un;
    logic        pd_chk;
    logic [15:0] pd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rs, logic fl, logic pu, logic po, logic [15:0] d,
                              int w, int r, int rnd, int cnt, int ov, int un,
                              logic pc, logic [15:0] pd);
    vec_t v;
    v.rst = rs; v.flush = fl; v.push = pu; v.pop = po; v.data = d;
    v.w = w; v.r = r; v.rnd = rnd; v.cnt = cnt; v.ov = ov; v.un = un;
    v.pd_chk = pc; v.pd = pd;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(string tag, int w, int r, int rnd, int cnt, int ov, int un);
    check({tag, ".W_Addr"}, int'(W_Addr), w);
    check({tag, ".R_Addr"}, int'(R_Addr), r);
    check({tag, ".Round"}, int'(Round), rnd);
    check({tag, ".Count"}, int'(Count), cnt);
    check({tag, ".Full"}, int'(Full), (cnt == 4) ? 1 : 0);
    check({tag, ".Empty"}, int'(Empty), (cnt == 0) ? 1 : 0);
    check({tag, ".Overflow"}, int'(Overflow), ov);
    check({tag, ".Underflow"}, int'(Underflow), un);
  endtask

  // Reference model: plain queue of operands plus read position and sticky flags.
  logic [15:0] mq[$];
  int          m_rptr;
  int          m_ov;
  int          m_un;

  task automatic model_apply(logic rs, logic fl, logic pu, logic po, logic [15:0] d);
    int sz;
    bit pop_ok;
    bit push_ok;
    sz = mq.size();
    if (rs || fl) begin
      mq.delete();
      m_rptr = 0;
      m_ov = 0;
      m_un = 0;
    end else begin
      pop_ok  = po && (sz > 0);
      push_ok = pu && ((sz < 4) || po);
      if (po && sz == 0) m_un = 1;
      if (pu && !push_ok) m_ov = 1;
      if (pop_ok) begin
        void'(mq.pop_front());
        m_rptr = (m_rptr + 1) % 4;
      end
      if (push_ok) mq.push_back(d);
    end
  endtask

  initial begin
    rst = 1'b1; Flush = 1'b0; Push = 1'b0; Pop = 1'b0; PushData = 16'h0000;

    //        rst   flush push  pop   data      w  r  rnd cnt ov un pdchk pd
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0011, 1, 0, 0, 1, 0, 0, 1'b1, 16'h0011));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0022, 2, 0, 0, 2, 0, 0, 1'b1, 16'h0011));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0033, 3, 0, 0, 3, 0, 0, 1'b1, 16'h0011));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0044, 0, 0, 1, 4, 0, 0, 1'b1, 16'h0011));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0055, 0, 0, 1, 4, 1, 0, 1'b1, 16'h0011));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 1, 1, 3, 1, 0, 1'b1, 16'h0022));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 2, 1, 2, 1, 0, 1'b1, 16'h0033));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 3, 1, 1, 1, 0, 1'b1, 16'h0044));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 0, 0, 0, 1, 0, 1'b0, 16'h0000));
    vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h00A5, 1, 0, 0, 1, 0, 1, 1'b1, 16'h00A5));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 2, 0, 0, 2, 0, 1, 1'b1, 16'h00A5));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 3, 0, 0, 3, 0, 1, 1'b1, 16'h00A5));
    vt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1, 0, 0, 1, 0, 0, 1'b1, 16'h0010));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 2, 0, 0, 2, 0, 0, 1'b1, 16'h0010));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 3, 0, 0, 3, 0, 0, 1'b1, 16'h0010));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3, 1, 0, 2, 0, 0, 1'b1, 16'h0020));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3, 2, 0, 1, 0, 0, 1'b1, 16'h0030));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3, 3, 0, 0, 0, 0, 1'b0, 16'h0000));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 0, 3, 1, 1, 0, 0, 1'b1, 16'h0040));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0050, 1, 3, 1, 2, 0, 0, 1'b1, 16'h0040));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0060, 2, 3, 1, 3, 0, 0, 1'b1, 16'h0040));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0070, 3, 3, 1, 4, 0, 0, 1'b1, 16'h0040));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0080, 0, 0, 1, 4, 0, 0, 1'b1, 16'h0050));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0090, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000));

    foreach (vt[i]) begin
      rst = vt[i].rst; Flush = vt[i].flush; Push = vt[i].push; Pop = vt[i].pop;
      PushData = vt[i].data;
      step();
      check_state($sformatf("vec%0d", i), vt[i].w, vt[i].r, vt[i].rnd, vt[i].cnt,
                  vt[i].ov, vt[i].un);
      if (vt[i].pd_chk) check($sformatf("vec%0d.PopData", i), int'(PopData), int'(vt[i].pd));
    end

    // Hand-written sequence: a push into a full buffer without pop must keep the
    // stored operands intact, and a flush must not erase storage either.
    rst = 1'b1; Flush = 1'b0; Push = 1'b0; Pop = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      Push = 1'b1; PushData = 16'hC000 + 16'(k);
      step();
    end
    Push = 1'b1; PushData = 16'hDEAD;
    step();
    check("seq.ovf_head", int'(PopData), 16'hC000);
    Push = 1'b0; Pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seq.drain%0d", k), int'(PopData), int'(16'hC000 + 16'(k)));
      step();
    end
    Pop = 1'b0; Flush = 1'b1;
    step();
    Flush = 1'b0;
    check("seq.flush_keeps_mem", int'(PopData), 16'hC000);
    check_state("seq.after_flush", 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    mq.delete(); m_rptr = 0; m_ov = 0; m_un = 0;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      Flush    = ($urandom_range(0, 39) == 0);
      Push     = ($urandom_range(0, 99) < 55);
      Pop      = ($urandom_range(0, 99) < 50);
      PushData = 16'($urandom);
      if (Pop && !rst && !Flush && mq.size() > 0)
        check($sformatf("rnd%0d.consumed", c), int'(PopData), int'(mq[0]));
      model_apply(rst, Flush, Push, Pop, PushData);
      step();
      check_state($sformatf("rnd%0d", c), (m_rptr + mq.size()) % 4, m_rptr,
                  (m_rptr + mq.size() >= 4) ? 1 : 0, mq.size(), m_ov, m_un);
      if (mq.size() > 0) check($sformatf("rnd%0d.PopData", c), int'(PopData), int'(mq[0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
